seg7_scan_ctrl: RTL and testbench

Parametrised N-digit multiplexed 7-segment scan controller for the board display path. It accepts a packed nibble word from upstream logic (counters, BCD converters) and time-multiplexes the digits. Over the 4-digit fixed-decimal controller it adds: configurable digit count and refresh rate, tear-free double buffering, hex mode, decimal points, leading-zero blanking, anti-ghost blanking and PWM brightness.

---
 rtl/seg7_scan_ctrl_if.sv | 36 +++
 rtl/seg7_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl_if
// Description : Bus between upstream display logic and the 7-segment scan
//               controller: data/control inputs plus the panel drive outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      hex_mode;
  logic                      lz_blank;
  logic [BRIGHT_W-1:0]       brightness;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     digit;
  logic                      frame_done;

  // Upstream logic drives the data/control side and observes the panel side
  modport master (
    output enable, load, value, dp_in, hex_mode, lz_blank, brightness,
    input  seg, dp, digit, frame_done
  );

  // The scan controller consumes data/control and drives the panel
  modport slave (
    input  enable, load, value, dp_in, hex_mode, lz_blank, brightness,
    output seg, dp, digit, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : N-digit multiplexed 7-segment scan controller with double
//               buffering, hex/decimal glyphs, decimal points, leading-zero
//               blanking, anti-ghost blanking and PWM brightness.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000,
  parameter int BRIGHT_W        = 4,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int DIG_ACTIVE_LOW  = 1
) (
  input  logic           clk_100MHz,
  input  logic           reset,
  seg7_scan_ctrl_if.slave bus
);

  localparam int TMR_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(TICKS_PER_DIGIT - 1);
  localparam logic [TMR_W-1:0]      TMR_BLANK = TMR_W'(BLANK_TICKS);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic                  SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic                  DIG_INV   = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF   = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_INV}};
  localparam logic [6:0]            GLYPH_DASH = 7'b0000001;

  // Active-high abcdefg glyph for a nibble (0-9, A, b, C, d, E, F)
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    glyph = 7'b1111110;
      4'h1:    glyph = 7'b0110000;
      4'h2:    glyph = 7'b1101101;
      4'h3:    glyph = 7'b1111001;
      4'h4:    glyph = 7'b0110011;
      4'h5:    glyph = 7'b1011011;
      4'h6:    glyph = 7'b1011111;
      4'h7:    glyph = 7'b1110000;
      4'h8:    glyph = 7'b1111111;
      4'h9:    glyph = 7'b1111011;
      4'hA:    glyph = 7'b1110111;
      4'hB:    glyph = 7'b0011111;
      4'hC:    glyph = 7'b1001110;
      4'hD:    glyph = 7'b0111101;
      4'hE:    glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  logic [TMR_W-1:0]        timer;
  logic [IDX_W-1:0]        index;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    pending;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   digit_q;
  logic                    frame_done_q;

  logic                    terminal;
  logic                    wrap;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic [6:0]              seg_ah;
  logic [NUM_DIGITS-1:0]   digit_ah;
  logic                    pwm_on;
  logic                    digit_on;

  assign terminal = (timer == TMR_LAST);
  assign wrap     = terminal && (index == IDX_LAST);
  assign nibble   = disp[4*index +: 4];
  assign pwm_on   = (bus.brightness == '1) || (pwm_cnt < bus.brightness);
  assign digit_on = bus.enable && (timer >= TMR_BLANK) && pwm_on;

  // A digit above 0 is a leading zero when it and every higher nibble is zero
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (disp[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  // Glyph and one-hot enable for the digit currently being scanned
  always_comb begin
    seg_ah          = glyph(nibble);
    digit_ah        = '0;
    digit_ah[index] = 1'b1;
    if (bus.lz_blank && lz_mask[index]) begin
      seg_ah = 7'b0000000;
    end else if (!bus.hex_mode && (nibble > 4'h9)) begin
      seg_ah = GLYPH_DASH;
    end
  end

  // Slot timer and digit index; parked at digit 0 slot start while disabled
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      timer   <= '0;
      index   <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (!bus.enable) begin
        timer <= '0;
        index <= '0;
      end else if (terminal) begin
        timer <= '0;
        index <= (index == IDX_LAST) ? '0 : index + 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Double buffer: display only takes the shadow at frame wrap (or freely when dark)
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      shadow    <= '0;
      shadow_dp <= '0;
      disp      <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else begin
      if (!bus.enable || (wrap && pending)) begin
        disp    <= shadow;
        disp_dp <= shadow_dp;
      end
      if (bus.load) begin
        shadow    <= bus.value;
        shadow_dp <= bus.dp_in;
        pending   <= 1'b1;
      end else if (!bus.enable || wrap) begin
        pending   <= 1'b0;
      end
    end
  end

  // Registered panel drive with polarity applied; dark whenever no digit is on
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_INV;
      digit_q      <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= bus.enable && wrap;
      if (digit_on) begin
        seg_q   <= seg_ah ^ SEG_OFF;
        dp_q    <= disp_dp[index] ^ SEG_INV;
        digit_q <= digit_ah ^ DIG_OFF;
      end else begin
        seg_q   <= SEG_OFF;
        dp_q    <= SEG_INV;
        digit_q <= DIG_OFF;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit      = digit_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl (4 digits, 8-clock
//               slots with 2-clock dark gap, active-low outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int TICKS      = 8;
  localparam int BLANK      = 2;
  localparam int BRIGHT_W   = 4;

  typedef struct {
    logic [15:0]      value;
    logic [3:0]       dp_in;
    logic             hex;
    logic             lz;
    logic [3:0][6:0]  exp_seg;  // {digit3, digit2, digit1, digit0}, active-low
    logic [3:0]       exp_dp;   // active-low
  } vec_t;

  typedef struct {
    logic [3:0] bright;
    int         exp_on;
  } bvec_t;

  logic clk_100MHz = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t  vecs[8];
  bvec_t bvecs[5];

  seg7_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS      (NUM_DIGITS),
    .TICKS_PER_DIGIT (TICKS),
    .BLANK_TICKS     (BLANK),
    .BRIGHT_W        (BRIGHT_W),
    .SEG_ACTIVE_LOW  (1),
    .DIG_ACTIVE_LOW  (1)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " digit"},      bus.digit,      4'hF);
    check({tag, " seg"},        bus.seg,        7'h7F);
    check({tag, " dp"},         bus.dp,         1'b1);
    check({tag, " frame_done"}, bus.frame_done, 1'b0);
  endtask

  // Wait (bounded) until a frame_done sample; leaves the bench at frame slot j=31
  task automatic sync_frame();
    int n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 100);
    check("frame_sync", bus.frame_done, 1'b1);
  endtask

  // Check one full frame, cycle by cycle; optionally pulse load at sample load_at
  task automatic check_frame(input logic [3:0][6:0] es, input logic [3:0] ed,
                             input int load_at, input logic [15:0] load_val);
    int         s;
    logic [3:0] exp_dig;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk_100MHz);
      bus.load = 1'b0;
      s = j / 8;
      if ((j % 8) >= BLANK) begin
        exp_dig = ~(4'b0001 << s);
        check($sformatf("digit j=%0d", j), bus.digit, exp_dig);
        check($sformatf("seg j=%0d", j),   bus.seg,   es[s]);
        check($sformatf("dp j=%0d", j),    bus.dp,    ed[s]);
      end else begin
        check($sformatf("gap digit j=%0d", j), bus.digit, 4'hF);
        check($sformatf("gap seg j=%0d", j),   bus.seg,   7'h7F);
      end
      check($sformatf("frame_done j=%0d", j), bus.frame_done, (j == 31));
      if (j == load_at) begin
        bus.load  = 1'b1;
        bus.value = load_val;
        bus.dp_in = 4'h0;
      end
    end
  endtask

  task automatic apply_vec(input vec_t v);
    sync_frame();
    bus.load     = 1'b1;
    bus.value    = v.value;
    bus.dp_in    = v.dp_in;
    bus.hex_mode = v.hex;
    bus.lz_blank = v.lz;
    @(negedge clk_100MHz);
    bus.load = 1'b0;
    sync_frame();
    check_frame(v.exp_seg, v.exp_dp, -1, 16'h0);
  endtask

  initial begin
    int on_cnt;

    vecs[0] = '{16'h1234, 4'h0, 1'b0, 1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF};
    vecs[1] = '{16'h0045, 4'h0, 1'b0, 1'b1, {7'b1111111, 7'b1111111, 7'b1001100, 7'b0100100}, 4'hF};
    vecs[2] = '{16'h0000, 4'h0, 1'b0, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'hF};
    vecs[3] = '{16'h0045, 4'h0, 1'b0, 1'b0, {7'b0000001, 7'b0000001, 7'b1001100, 7'b0100100}, 4'hF};
    vecs[4] = '{16'hABCD, 4'h0, 1'b1, 1'b0, {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}, 4'hF};
    vecs[5] = '{16'hABCD, 4'h0, 1'b0, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'hF};
    vecs[6] = '{16'h0509, 4'b1001, 1'b0, 1'b1, {7'b1111111, 7'b0100100, 7'b0000001, 7'b0000100}, 4'b0110};
    vecs[7] = '{16'h9876, 4'h0, 1'b0, 1'b0, {7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000}, 4'hF};

    // Active samples over the first 64 cycles after reset: timer phase t%8>=2, pwm phase t%16<b
    bvecs[0] = '{4'h0, 0};
    bvecs[1] = '{4'h4, 8};
    bvecs[2] = '{4'h8, 24};
    bvecs[3] = '{4'hE, 40};
    bvecs[4] = '{4'hF, 48};

    reset          = 1'b1;
    bus.enable     = 1'b1;
    bus.load       = 1'b0;
    bus.value      = '0;
    bus.dp_in      = '0;
    bus.hex_mode   = 1'b0;
    bus.lz_blank   = 1'b0;
    bus.brightness = 4'hF;

    repeat (3) @(negedge clk_100MHz);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Display buffer cleared by reset: first frame shows 0000
    check_frame({4{7'b0000001}}, 4'hF, -1, 16'h0);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Tear-free load mid-frame, then a load coinciding with the wrap edge
    apply_vec(vecs[0]);
    check_frame(vecs[0].exp_seg, 4'hF, 10, 16'h9999);
    check_frame({4{7'b0000100}}, 4'hF, 30, 16'h5555);
    check_frame({4{7'b0000100}}, 4'hF, -1, 16'h0);
    check_frame({4{7'b0100100}}, 4'hF, -1, 16'h0);

    // Asynchronous reset while digit 0 is lit
    repeat (4) @(negedge clk_100MHz);
    check("pre-reset digit", bus.digit, 4'b1110);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async reset");
    @(negedge clk_100MHz);
    reset = 1'b0;
    check_frame({4{7'b0000001}}, 4'hF, -1, 16'h0);

    // Disabled: dark, no frame_done, loads go straight to display
    bus.enable = 1'b0;
    bus.load   = 1'b1;
    bus.value  = 16'h2468;
    bus.dp_in  = 4'h0;
    @(negedge clk_100MHz);
    bus.load = 1'b0;
    for (int k = 0; k < 64; k++) begin
      check($sformatf("disabled digit k=%0d", k), bus.digit, 4'hF);
      check($sformatf("disabled frame_done k=%0d", k), bus.frame_done, 1'b0);
      @(negedge clk_100MHz);
    end
    bus.enable = 1'b1;
    check_frame({7'b0010010, 7'b1001100, 7'b0100000, 7'b0000000}, 4'hF, -1, 16'h0);

    // PWM brightness: count lit samples in 64 cycles from reset release
    foreach (bvecs[i]) begin
      reset          = 1'b1;
      bus.brightness = bvecs[i].bright;
      @(negedge clk_100MHz);
      reset  = 1'b0;
      on_cnt = 0;
      for (int k = 0; k < 64; k++) begin
        @(negedge clk_100MHz);
        if (bus.digit !== 4'hF) on_cnt++;
      end
      check($sformatf("bright=%0d lit count", bvecs[i].bright), on_cnt, bvecs[i].exp_on);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
